// File: rtl/line_burst_pkg.sv
// line_burst_pkg
//   Shared types and sizing for the cache-line / memory-burst adaptor.
//   A 256-bit cache line moves as four 64-bit beats, lowest beat first.
//   The line address is aligned to 32 bytes by clearing the low 5 bits.
package line_burst_pkg;

  localparam int BEATS_PER_LINE = 4;
  localparam int BEAT_W         = 64;
  localparam int LINE_W         = 256;
  localparam int OFFSET_BITS    = 5;

  // Clears the byte-offset bits of a line address.
  localparam logic [31:0] LINE_ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } lba_state_t;

endpackage

// File: rtl/line_burst_adaptor.sv
// line_burst_adaptor
//   Converts single-cycle cache line fills and write-backs into four-beat
//   bursts on the physical memory port.
//
// Ports
//   clk, rst     : sole clock, synchronous active-high reset
//   line_i       : 256-bit write-back line from the cache
//   line_o       : 256-bit assembled fill line to the cache
//   address_i    : cache line address (byte offset ignored)
//   read_i       : fill request, held until resp_o
//   write_i      : write-back request, held until resp_o (wins over read_i)
//   resp_o       : one-cycle completion pulse
//   burst_i      : 64-bit read beat from memory
//   burst_o      : 64-bit write beat to memory
//   address_o    : line-aligned address, stable for the whole transaction
//   read_o       : burst read request, high throughout RD_BURST
//   write_o      : burst write request, high throughout WR_BURST
//   resp_i       : beat accepted (write) / beat valid (read)
module line_burst_adaptor
  import line_burst_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [LINE_W-1:0]   line_i,
  output logic [LINE_W-1:0]   line_o,
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  input  logic [BEAT_W-1:0]   burst_i,
  output logic [BEAT_W-1:0]   burst_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  lba_state_t          state_q, state_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [LINE_W-1:0]   wr_line_q, wr_line_d;
  logic [LINE_W-1:0]   fill_q, fill_d;
  logic [31:0]         addr_q, addr_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                resp_q, resp_d;

  // State and datapath registers; reset also discards a partial fill line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      wr_line_q <= '0;
      fill_q    <= '0;
      addr_q    <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      resp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_line_q <= wr_line_d;
      fill_q    <= fill_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      write_q   <= write_d;
      resp_q    <= resp_d;
    end
  end

  // Next-state and datapath updates. Requests are only looked at in IDLE,
  // and resp_i only inside a burst, so stray strobes elsewhere are harmless.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_line_d = wr_line_q;
    fill_d    = fill_q;
    addr_d    = addr_q;
    unique case (state_q)
      IDLE: begin
        if (write_i) begin
          wr_line_d = line_i;
          addr_d    = address_i & LINE_ADDR_MASK;
          cnt_d     = 2'd0;
          state_d   = WR_BURST;
        end else if (read_i) begin
          addr_d    = address_i & LINE_ADDR_MASK;
          cnt_d     = 2'd0;
          state_d   = RD_BURST;
        end
      end
      RD_BURST: begin
        if (resp_i) begin
          fill_d[BEAT_W*int'(cnt_q) +: BEAT_W] = burst_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'(BEATS_PER_LINE - 1)) state_d = DONE;
        end
      end
      WR_BURST: begin
        if (resp_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'(BEATS_PER_LINE - 1)) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the block
  // straight from flops and line up with the state they describe.
  always_comb begin
    read_d  = (state_d == RD_BURST);
    write_d = (state_d == WR_BURST);
    resp_d  = (state_d == DONE);
  end

  assign line_o    = fill_q;
  assign address_o = addr_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;
  // Write data is a mux of registered line and registered beat index.
  assign burst_o   = wr_line_q[BEAT_W*int'(cnt_q) +: BEAT_W];

endmodule

// File: doc/line_burst_adaptor.md
LINE_BURST_ADAPTOR -- requirements
Module: line_burst_adaptor

Interface
REQ-001 SHALL have ports, in order:
- clk, input, 1: sole clock.
- rst, input, 1: reset; synchronous and active-high.
REQ-002 SHALL have cache-side ports:
- line_i, input, 256: write-back line.
- line_o, output, 256: assembled fill line.
- address_i, input, 32: line address.
- read_i, input, 1: fill request, level-held until resp_o.
- write_i, input, 1: write-back request, level-held until resp_o.
- resp_o, output, 1: one-cycle completion pulse.
REQ-003 SHALL have memory-side ports:
- burst_i, input, 64: read beat data.
- burst_o, output, 64: write beat data.
- address_o, output, 32: line-aligned address.
- read_o, output, 1: burst read request.
- write_o, output, 1: burst write request.
- resp_i, input, 1: beat accepted/valid.
REQ-004 SHALL have one clock; reset is synchronous and active-high (clk, rst).
REQ-005 SHALL drive every output from a register (no combinational input-to-output path), except burst_o, which is a mux of the registered line indexed by the registered beat counter.

Function
REQ-006 SHALL implement states IDLE, RD_BURST, WR_BURST and DONE; the state is held in a 2-bit register with a 2-bit beat counter.
REQ-007 In IDLE with write_i=1, SHALL latch line_i, latch {address_i[31:5],5'b0} into address_o, clear the counter and enter WR_BURST; write_i takes priority when read_i=1 at the same time.
REQ-008 In IDLE with read_i=1 and write_i=0, SHALL latch the aligned address, clear the counter and enter RD_BURST.
REQ-009 read_o SHALL be 1 exactly while the state is RD_BURST; write_o SHALL be 1 exactly while the state is WR_BURST.
REQ-010 In RD_BURST, each cycle with resp_i=1 SHALL store burst_i into line_o[64*cnt +: 64] and increment cnt.
REQ-011 In WR_BURST, burst_o SHALL equal line[64*cnt +: 64]; each cycle with resp_i=1 SHALL increment cnt.
REQ-012 Beats SHALL be in ascending order: beat 0 is bits [63:0] and beat 3 is bits [255:192].
REQ-013 The cycle with resp_i=1 and cnt=3 SHALL move the state to DONE; the counter wraps to 0.
REQ-014 resp_o SHALL be 1 for exactly the one cycle the state is DONE; DONE SHALL then return unconditionally to IDLE.
REQ-015 In DONE, line_o SHALL hold the complete fill line, and it SHALL remain stable until the next read burst begins.
REQ-016 Cycles with resp_i=0 inside a burst SHALL stall: cnt and data are unchanged, with no timeout.
REQ-017 resp_i SHALL be ignored in IDLE and DONE.
REQ-018 read_i and write_i SHALL be ignored outside IDLE; a request still high in the IDLE cycle after DONE starts a new transaction.
REQ-019 Minimum latency SHALL be:
- request seen in IDLE at cycle 0;
- read_o/write_o high from cycle 1;
- 4 back-to-back beats at cycles 1-4;
- resp_o at cycle 5.
REQ-020 address_o SHALL remain constant for the whole of a transaction.

Reset
REQ-021 On a clock edge with rst=1, the block SHALL enter IDLE with cnt=0, line_o=0, address_o=0, read_o=0, write_o=0 and resp_o=0.
REQ-022 rst asserted mid-burst SHALL abort the transaction:
- no resp_o is generated;
- partially assembled line_o is cleared to 0.
REQ-023 rst SHALL take precedence over all requests and over resp_i in the same cycle.

Structure
REQ-024 The package line_burst_pkg SHALL define:
- state enum lba_state_t;
- BEATS_PER_LINE=4;
- BEAT_W=64;
- LINE_W=256;
- OFFSET_BITS=5.
REQ-025 The block SHALL be one module with no sub-module; the beat counter and state register are local.
REQ-026 The block SHALL sit between the cache datapath (the 256-bit line/byte-enable side) and the physical memory burst port, and SHALL be instantiated once per cache.

Verification
REQ-027 Read with resp_i continuous: read_i=1, address_i=0x0000_1234, burst_i=0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220, read_o high for 4 cycles, resp_o at cycle 5, line_o={0x44..,0x33..,0x22..,0x11..}.
REQ-028 Write with stalls: write_i=1, line_i=0xDDDD..CCCC..BBBB..AAAA, resp_i pattern 1,0,0,1,1,0,1 -> burst_o sequence 0xAAAA.., 0xBBBB.., 0xCCCC.., 0xDDDD.. advancing only on resp_i=1, resp_o one cycle after the 4th accepted beat.
REQ-029 Simultaneous request: read_i=write_i=1 in IDLE -> write_o=1 and read_o=0 throughout, exactly one resp_o.
REQ-030 Reset mid-read: rst=1 after 2 beats -> next cycle state IDLE, read_o=0, line_o=0, no resp_o; a subsequent read completes normally.
REQ-031 Back-to-back requests: read_i held high after resp_o -> new RD_BURST begins 2 cycles after resp_o; spurious resp_i=1 in IDLE leaves line_o and cnt unchanged.
